alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - Issue/result ALU: single-cycle ops plus iterative shift-add MUL and restoring DIV
module alu_exec #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] rem,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic [4:0]       rd_out,
  output logic             reg_write_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_OR   = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b00110;
  localparam logic [4:0] OP_SLL  = 5'b01000;
  localparam logic [4:0] OP_SRL  = 5'b01001;
  localparam logic [4:0] OP_SRA  = 5'b01010;
  localparam logic [4:0] OP_SLT  = 5'b01011;
  localparam logic [4:0] OP_SLTU = 5'b01100;
  localparam logic [4:0] OP_PASS = 5'b01101;
  localparam logic [4:0] OP_INC  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;
  logic [4:0]         rd_q, rd_d;
  logic               rw_q, rw_d;

  logic               accept;
  logic               last_iter;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf, alu_ill;
  logic [WIDTH:0]     add_sum, inc_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH:0]     div_shift;
  logic               div_neg;
  logic [WIDTH-1:0]   div_diff;

  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Single-cycle operations, evaluated directly on the issue-side operands.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    add_sum   = {1'b0, op_a} + {1'b0, op_b};
    inc_sum   = {1'b0, op_a} + {{WIDTH{1'b0}}, 1'b1};
    sub_diff  = op_a - op_b;
    case (alu_op)
      OP_ADD: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
        alu_ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_diff;
        alu_carry = op_a < op_b;
        alu_ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_SLL:  alu_res = op_a << op_b[3:0];
      OP_SRL:  alu_res = op_a >> op_b[3:0];
      OP_SRA:  alu_res = WIDTH'($signed(op_a) >>> op_b[3:0]);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      OP_PASS: alu_res = op_b;
      OP_INC: begin
        alu_res   = inc_sum[WIDTH-1:0];
        alu_carry = inc_sum[WIDTH];
        alu_ovf   = !op_a[WIDTH-1] && inc_sum[WIDTH-1];
      end
      OP_MUL, OP_DIV: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // work_q holds {high, low}: product accumulator for MUL, {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, work_q[WIDTH-1:1]};
    div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_neg   = div_shift < {1'b0, opnd_q};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_next  = div_neg ? {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                        : {div_diff, work_q[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (alu_op == OP_MUL)                      state_d = S_MUL;
          else if (alu_op == OP_DIV && op_b != '0)   state_d = S_DIV;
          else                                       state_d = S_DONE;
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (last_iter) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    rem_d    = rem_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    if (accept) begin
      rd_d     = rd_in;
      rw_d     = reg_write_in && !alu_ill;
      result_d = alu_res;
      rem_d    = '0;
      zero_d   = (alu_res == '0);
      carry_d  = alu_carry;
      ovf_d    = alu_ovf;
      dbz_d    = 1'b0;
      ill_d    = alu_ill;
      if (alu_op == OP_MUL) begin
        work_d = {{WIDTH{1'b0}}, op_b};
        opnd_d = op_a;
        cnt_d  = '0;
      end else if (alu_op == OP_DIV) begin
        if (op_b == '0) begin
          result_d = '1;
          rem_d    = op_a;
          zero_d   = 1'b0;
          dbz_d    = 1'b1;
        end else begin
          work_d = {{WIDTH{1'b0}}, op_a};
          opnd_d = op_b;
          cnt_d  = '0;
        end
      end
    end else if (state_q == S_MUL) begin
      work_d = mul_next;
      cnt_d  = cnt_q + 1'b1;
      if (last_iter) begin
        result_d = mul_next[WIDTH-1:0];
        zero_d   = (mul_next[WIDTH-1:0] == '0);
        ovf_d    = |mul_next[2*WIDTH-1:WIDTH];
      end
    end else if (state_q == S_DIV) begin
      work_d = div_next;
      cnt_d  = cnt_q + 1'b1;
      if (last_iter) begin
        result_d = div_next[WIDTH-1:0];
        rem_d    = div_next[2*WIDTH-1:WIDTH];
        zero_d   = (div_next[WIDTH-1:0] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      rem_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
    end
  end

  assign result        = result_q;
  assign rem           = rem_q;
  assign zero          = zero_q;
  assign carry         = carry_q;
  assign overflow      = ovf_q;
  assign div_by_zero   = dbz_q;
  assign illegal_op    = ill_q;
  assign rd_out        = rd_q;
  assign reg_write_out = rw_q;

endmodule
